fmap_writer: RTL and testbench
==============================

# fmap_writer

Collects half-row results from the convolution units and assembles them into a complete output feature map for one filter. It is the write-side counterpart to the receptive-field selector. It generates the row number and column-half select that the selector consumes, and it accepts one half-row of conv outputs per handshake. When the map is full, it presents the map downstream with a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 32, width of one output pixel
- `S`, 5, filter size
- `H`, 32, input image height
- `W`, 32, input image width
- Derived, not overridable: `OH = H-S+1`, `OW = W-S+1`, `HALF = OW/2`, `HALF2 = OW-HALF`
- `clk`, in, 1, single clock; all state changes on its rising edge
- `rst_n`, in, 1, reset: synchronous, active-low
- `start`, in, 1, single-cycle pulse that begins a new map
- `in_valid`, in, 1, a half-row is present on `in_data`
- `in_ready`, out, 1, block accepts a half-row this cycle
- `in_data`, in, `HALF2*DATA_WIDTH`, ascending bit range `[0:...]`; pixel j at `[j*DATA_WIDTH +: DATA_WIDTH]`
- `row_num`, out, 6, output row expected next; drives the selector's row input
- `col_sel`, out, 1, half expected next (0 = columns 0..HALF-1, 1 = HALF..OW-1)
- `busy`, out, 1, high in FILL and DONE
- `fmap_valid`, out, 1, full map available
- `fmap_ready`, in, 1, downstream accepts the map
- `fmap`, out, `OH*OW*DATA_WIDTH`, ascending range; pixel (r,c) at `[(r*OW+c)*DATA_WIDTH +: DATA_WIDTH]`

## Operation
- FSM states: IDLE, FILL, DONE.
  - IDLE → FILL on `start`. Entering FILL clears `row_num` and `col_sel` to 0. `fmap` contents are retained until overwritten.
  - FILL: `in_ready`=1. On each `in_valid && in_ready` beat the block writes pixels at columns `col_sel*HALF + j`:
    - for `col_sel`=0: j = 0..HALF-1;
    - for `col_sel`=1: j = 0..HALF2-1;
    - unused upper entries of `in_data` are ignored.
  - After a write with `col_sel`=0: set `col_sel`=1.
  - After a write with `col_sel`=1: set `col_sel`=0 and increment `row_num`.
  - The beat at (`row_num`=OH-1, `col_sel`=1) goes to DONE. In that case `row_num` and `col_sel` hold at OH-1 and 1; they do not wrap.
  - DONE: `fmap_valid`=1 and `fmap` stays stable. On `fmap_valid && fmap_ready`, go to IDLE.
- `start` is ignored outside IDLE.
- `in_valid` is ignored outside FILL; no write occurs.
- `in_ready` is combinational from state only and never depends on `in_valid`.
- `busy` = (state != IDLE).
- Reset (`rst_n`=0 at a clock edge, in any state including mid-FILL or DONE):
  - state → IDLE;
  - `row_num`=0, `col_sel`=0;
  - `fmap` cleared to all zero;
  - `in_ready`=0, `fmap_valid`=0, `busy`=0.
  - A partially filled map is discarded.
- No arithmetic is performed on pixel data; words are stored bit-exact.

## Timing
- Accept: a write on edge N is visible on `fmap` after edge N. `row_num`/`col_sel` advance on the same edge.
- One half-row per cycle maximum. A full map takes at least 2*OH accepted beats.
- `fmap_valid` rises the cycle after the final beat is accepted.
- `start` to `in_ready`=1 takes 1 cycle.
- `fmap_valid` falls the cycle after the `fmap_ready` handshake. `in_ready` stays 0 until the next `start` is seen in IDLE.
- `start` asserted in the same cycle as the DONE handshake is ignored, because the state is still DONE.

## Structure
- Shared header `cnn_params.vh`: derived localparams `OH`, `OW`, `HALF`, `HALF2`, and FSM state encodings. The selector and the conv array include the same header.
- Natural sub-module: `fmap_wr_ctrl`, which holds the FSM plus the `row_num`/`col_sel` counters and outputs write-enable and base address. The top level holds the storage array and the write mux.

## Test plan
Use S=3, H=6, W=6, giving OH=4, OW=4, HALF=2. Pixel value = `16*r + c`.

1. Reset, then `start`, then 8 back-to-back beats → `row_num`/`col_sel` step through (0,0),(0,1),(1,0)…(3,1). `fmap_valid`=1 one cycle after beat 8. Pixel (2,3)=0x23.
2. Hold `fmap_ready`=0 for 5 cycles in DONE → `fmap` stable and `fmap_valid` held. Then assert `fmap_ready` → IDLE next cycle and `busy`=0.
3. Gaps in `in_valid` (every other cycle) → same final map as scenario 1. Counters advance only on accepted beats.
4. Assert `rst_n`=0 after beat 5 → all outputs return to 0 and `fmap` is all zero. A new `start` then fills a clean map.
5. Pulse `start` during FILL, and drive `in_valid` during IDLE/DONE → no state or data change.
6. W=7 (OW=5, HALF=2, HALF2=3) → the second-half beat writes columns 2..4. Entry 2 of the first-half beat is ignored.

Source files
------------

// File: rtl/fmap_writer_pkg.sv
// Shared types for the feature-map write path: FSM encoding and counter widths.
package fmap_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fmap_state_t;

    localparam int ROW_W = 6;

endpackage

// File: rtl/fmap_wr_ctrl.sv
// Sequencing for the feature-map writer: FSM, row/half counters and write strobe.
module fmap_wr_ctrl
    import fmap_writer_pkg::*;
#(
    parameter int OH = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic             fmap_ready,
    output logic             in_ready,
    output logic             wr_en,
    output logic [ROW_W-1:0] row_num,
    output logic             col_sel,
    output logic             busy,
    output logic             fmap_valid
);

    fmap_state_t      state_reg;
    logic [ROW_W-1:0] row_reg;
    logic             col_reg;
    logic             busy_reg;
    logic             valid_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            row_reg   <= '0;
            col_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_FILL;
                        row_reg   <= '0;
                        col_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (in_valid) begin
                        if (!col_reg) begin
                            col_reg <= 1'b1;
                        end else if (row_reg == ROW_W'(OH - 1)) begin
                            // Last half-row: counters hold at the final position.
                            state_reg <= ST_DONE;
                            valid_reg <= 1'b1;
                        end else begin
                            row_reg <= row_reg + 1'b1;
                            col_reg <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    if (fmap_ready) begin
                        state_reg <= ST_IDLE;
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = (state_reg == ST_FILL);
    assign wr_en      = in_ready && in_valid;
    assign row_num    = row_reg;
    assign col_sel    = col_reg;
    assign busy       = busy_reg;
    assign fmap_valid = valid_reg;

endmodule

// File: rtl/fmap_writer.sv
// Assembles half-row conv results into one output feature map and hands it
// downstream with a valid/ready handshake.
module fmap_writer
    import fmap_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int S          = 5,
    parameter int H          = 32,
    parameter int W          = 32,
    localparam int OH        = H - S + 1,
    localparam int OW        = W - S + 1,
    localparam int HALF      = OW / 2,
    localparam int HALF2     = OW - HALF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [0:HALF2*DATA_WIDTH-1]       in_data,
    output logic [ROW_W-1:0]                  row_num,
    output logic                              col_sel,
    output logic                              busy,
    output logic                              fmap_valid,
    input  logic                              fmap_ready,
    output logic [0:OH*OW*DATA_WIDTH-1]       fmap
);

    logic wr_en;

    fmap_wr_ctrl #(
        .OH (OH)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .fmap_ready (fmap_ready),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .row_num    (row_num),
        .col_sel    (col_sel),
        .busy       (busy),
        .fmap_valid (fmap_valid)
    );

    // One register per pixel; each knows statically which half-row beat and
    // which in_data lane feeds it, so the write mux reduces to a compare.
    genvar gi;
    generate
        for (gi = 0; gi < OH * OW; gi++) begin : g_pix
            localparam int   R    = gi / OW;
            localparam int   C    = gi % OW;
            localparam logic HSEL = (C >= HALF);
            localparam int   J    = (C >= HALF) ? (C - HALF) : C;

            logic [DATA_WIDTH-1:0] pix_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    pix_reg <= '0;
                end else if (wr_en && (row_num == ROW_W'(R)) && (col_sel == HSEL)) begin
                    pix_reg <= in_data[J*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            assign fmap[gi*DATA_WIDTH +: DATA_WIDTH] = pix_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fmap_writer.sv
// Scoreboard bench: two writers (OW=4 and OW=5) driven in lockstep.
module tb_fmap_writer;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic fmap_ready = 1'b0;
    logic [0:2*DW-1] in_data_a = '0;
    logic [0:3*DW-1] in_data_b = '0;

    logic in_ready_a, in_ready_b, col_sel_a, col_sel_b;
    logic busy_a, busy_b, fmap_valid_a, fmap_valid_b;
    logic [5:0] row_num_a, row_num_b;
    logic [0:16*DW-1] fmap_a;
    logic [0:20*DW-1] fmap_b;

    int checks = 0;
    int errors = 0;

    int               exp_beats[$];
    logic [0:16*DW-1] exp_map_a[$];
    logic [0:20*DW-1] exp_map_b[$];

    always #5 clk = ~clk;

    fmap_writer #(.DATA_WIDTH(DW), .S(3), .H(6), .W(6)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_a), .in_data(in_data_a), .row_num(row_num_a),
        .col_sel(col_sel_a), .busy(busy_a), .fmap_valid(fmap_valid_a),
        .fmap_ready(fmap_ready), .fmap(fmap_a)
    );

    fmap_writer #(.DATA_WIDTH(DW), .S(3), .H(6), .W(7)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_b), .in_data(in_data_b), .row_num(row_num_b),
        .col_sel(col_sel_b), .busy(busy_b), .fmap_valid(fmap_valid_b),
        .fmap_ready(fmap_ready), .fmap(fmap_b)
    );

    task automatic chk(input string name, input logic [20*DW-1:0] act, input logic [20*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int r, input int c);
        return DW'(16 * r + c);
    endfunction

    function automatic logic [0:16*DW-1] full_map_a();
        logic [0:16*DW-1] m;
        m = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[(r*4+c)*DW +: DW] = pix(r, c);
        return m;
    endfunction

    function automatic logic [0:20*DW-1] full_map_b();
        logic [0:20*DW-1] m;
        m = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++)
                m[(r*5+c)*DW +: DW] = pix(r, c);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One half-row beat; dut_b gets a third lane, junk on the first half.
    task automatic beat(input int r, input int h);
        for (int j = 0; j < 2; j++)
            in_data_a[j*DW +: DW] = pix(r, h*2 + j);
        for (int j = 0; j < 3; j++)
            in_data_b[j*DW +: DW] = (h == 0 && j == 2) ? 32'hDEADBEEF : pix(r, h*2 + j);
        exp_beats.push_back(r*2 + h);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy_a"}, busy_a, 0);
        chk({tag, "_in_ready_a"}, in_ready_a, 0);
        chk({tag, "_fmap_valid_a"}, fmap_valid_a, 0);
        chk({tag, "_row_a"}, row_num_a, 0);
        chk({tag, "_col_a"}, col_sel_a, 0);
        chk({tag, "_fmap_a"}, fmap_a, 0);
        chk({tag, "_busy_b"}, busy_b, 0);
        chk({tag, "_fmap_b"}, fmap_b, 0);
    endtask

    // Monitor: compare counters on every accepted beat and the map on every handshake.
    always @(negedge clk) begin : monitor
        int e;
        if (in_valid && in_ready_a) begin
            if (exp_beats.size() == 0) begin
                chk("beat_unexpected", 1, 0);
            end else begin
                e = exp_beats.pop_front();
                chk("beat_row_a", row_num_a, e / 2);
                chk("beat_col_a", col_sel_a, e % 2);
                chk("beat_row_b", row_num_b, e / 2);
                chk("beat_col_b", col_sel_b, e % 2);
            end
        end
        if (fmap_valid_a && fmap_ready) begin
            if (exp_map_a.size() == 0) chk("map_a_unexpected", 1, 0);
            else chk("map_a", fmap_a, exp_map_a.pop_front());
        end
        if (fmap_valid_b && fmap_ready) begin
            if (exp_map_b.size() == 0) chk("map_b_unexpected", 1, 0);
            else chk("map_b", fmap_b, exp_map_b.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        check_idle_zero("reset");
        rst_n = 1'b1;
        tick();

        // Scenario 1: start, 8 back-to-back beats
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s1_in_ready_after_start", in_ready_a, 1);
        chk("s1_busy", busy_a, 1);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) chk("s1_valid_before_last", fmap_valid_a, 0);
            beat(k / 2, k % 2);
        end
        chk("s1_fmap_valid", fmap_valid_a, 1);
        chk("s1_fmap_valid_b", fmap_valid_b, 1);
        chk("s1_in_ready_done", in_ready_a, 0);
        chk("s1_row_hold", row_num_a, 3);
        chk("s1_col_hold", col_sel_a, 1);
        chk("s1_pix_2_3", fmap_a[(2*4+3)*DW +: DW], 32'h23);
        chk("s1_b_pix_1_4", fmap_b[(1*5+4)*DW +: DW], 32'h14);
        chk("s1_b_pix_2_2", fmap_b[(2*5+2)*DW +: DW], 32'h22);

        // Scenario 2: backpressure in DONE, then handshake with start/in_valid ignored
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s2_valid_held", fmap_valid_a, 1);
            chk("s2_fmap_stable", fmap_a, full_map_a());
        end
        exp_map_a.push_back(full_map_a());
        exp_map_b.push_back(full_map_b());
        in_data_a = {2{32'hBAD0BAD0}};
        in_data_b = {3{32'hBAD0BAD0}};
        fmap_ready = 1'b1;
        start = 1'b1;
        in_valid = 1'b1;
        tick();
        fmap_ready = 1'b0;
        start = 1'b0;
        chk("s2_busy_after_hs", busy_a, 0);
        chk("s2_valid_after_hs", fmap_valid_a, 0);
        chk("s2_in_ready_after_hs", in_ready_a, 0);

        // Scenario 5: in_valid in IDLE writes nothing
        tick();
        tick();
        in_valid = 1'b0;
        chk("s5_idle_in_ready", in_ready_a, 0);
        chk("s5_idle_busy", busy_a, 0);
        chk("s5_idle_fmap_a", fmap_a, full_map_a());
        chk("s5_idle_fmap_b", fmap_b, full_map_b());

        // Scenario 4: reset mid-fill after beat 5
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) beat(k / 2, k % 2);
        chk("s4_row_after5", row_num_a, 2);
        chk("s4_col_after5", col_sel_a, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle_zero("s4_reset");

        // Scenario 3: gaps between beats, plus a start pulse during FILL
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            beat(k / 2, k % 2);
            if (k == 2) start = 1'b1;
            tick();
            start = 1'b0;
            if (k < 7) begin
                chk("s3_gap_row", row_num_a, (k + 1) / 2);
                chk("s3_gap_col", col_sel_a, (k + 1) % 2);
            end
        end
        chk("s3_fmap_valid", fmap_valid_a, 1);
        chk("s3_fmap_clean", fmap_a, full_map_a());
        exp_map_a.push_back(full_map_a());
        exp_map_b.push_back(full_map_b());
        fmap_ready = 1'b1;
        tick();
        fmap_ready = 1'b0;
        chk("s3_busy_after_hs", busy_a, 0);
        tick();

        chk("beats_drained", exp_beats.size(), 0);
        chk("maps_drained", exp_map_a.size() + exp_map_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
